// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise / round / pack of an aligned floating-point sum.
// Define FPNORM_ROUND_MODES_EN to honour rnd_mode; otherwise RNE only.
module fp_norm_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 a_nan,
   input  logic                 b_nan,
   input  logic                 a_inf,
   input  logic                 b_inf,
   input  logic                 a_zero,
   input  logic                 b_zero,
   input  logic                 aligned_sign,
   input  logic [MAN_W+8:0]     aligned_result,
   input  logic                 carry_out,
   input  logic                 sticky,
   input  logic [EXP_W-1:0]     exponent_in,
   input  logic [1:0]           rnd_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact
);
   localparam int RES_W = MAN_W + 9;
   localparam int W     = EXP_W + MAN_W + 1;
   localparam int LZ_W  = $clog2(RES_W + 1);
   localparam int XW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
   localparam logic [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

   logic [2:1] vld_pipe_q;
   logic       s2_ready, s1_adv;

   assign s2_ready  = !vld_pipe_q[2] || out_ready;
   assign s1_adv    = vld_pipe_q[1] && s2_ready;
   assign in_ready  = !vld_pipe_q[1] || s1_adv;
   assign out_valid = vld_pipe_q[2];

   // ---------------- stage 1: classify, count leading zeros, shift
   logic             spec_d, zero_d;
   logic [W-1:0]     spec_res_d;
   logic [LZ_W-1:0]  lz_d;
   logic [RES_W-1:0] man_d;

   always_comb begin
      spec_d     = 1'b1;
      spec_res_d = '0;
      if (a_nan)                                   spec_res_d = a;
      else if (b_nan)                              spec_res_d = b;
      else if (a_inf && b_inf && (a[W-1] != b[W-1]))
         spec_res_d = {1'b0, {(EXP_W+MAN_W){1'b1}}};
      else if (a_inf)                              spec_res_d = a;
      else if (b_inf)                              spec_res_d = b;
      else if (a_zero)                             spec_res_d = b_zero ? a : b;
      else if (b_zero)                             spec_res_d = a;
      else                                         spec_d = 1'b0;
   end

   // highest set bit wins, so the last match in the upward scan is kept
   always_comb begin
      lz_d = LZ_W'(RES_W);
      for (int i = 0; i < RES_W; i++)
         if (aligned_result[i]) lz_d = LZ_W'(RES_W - 1 - i);
      man_d  = carry_out ? aligned_result : (aligned_result << lz_d);
      zero_d = !carry_out && (aligned_result == '0);
   end

   logic             spec_q, zero_q, sign_q, carry_q, stk_q;
   logic [W-1:0]     spec_res_q;
   logic [LZ_W-1:0]  lz_q;
   logic [RES_W-1:0] man_q;
   logic [EXP_W-1:0] exp_q;
   logic [1:0]       rm;

`ifdef FPNORM_ROUND_MODES_EN
   logic [1:0] rm_q;
   always_ff @(posedge clk) begin
      if (reset)                    rm_q <= 2'd0;
      else if (in_ready && in_valid) rm_q <= rnd_mode;
   end
   assign rm = rm_q;
`else
   logic unused_rnd_mode;
   assign unused_rnd_mode = ^rnd_mode;
   assign rm = 2'd0;
`endif

   // ---------------- stage 2: round, renormalise, pack
   logic               grd, rnd, stk, inx, inc, uf, ovf, to_inf;
   logic [MAN_W-1:0]   frac, frac_f;
   logic [MAN_W+1:0]   mant_r;
   logic [XW-1:0]      exp_ext, lz_ext, exp_f;
   logic [W-1:0]       res_d;
   logic               ovf_d, uf_d, inx_d;

   always_comb begin
      frac   = carry_q ? man_q[RES_W-1:9] : man_q[RES_W-2:8];
      grd    = carry_q ? man_q[8] : man_q[7];
      rnd    = carry_q ? man_q[7] : man_q[6];
      stk    = stk_q | (carry_q ? (|man_q[6:0]) : (|man_q[5:0]));
      inx    = grd | rnd | stk;
      inc    = 1'b0;
      case (rm)
         2'd0:    inc = grd & (rnd | stk | frac[0]);
         2'd2:    inc = inx & !sign_q;
         2'd3:    inc = inx & sign_q;
         default: inc = 1'b0;
      endcase
      mant_r  = {2'b01, frac} + {{(MAN_W+1){1'b0}}, inc};
      exp_ext = XW'(exp_q);
      lz_ext  = XW'(lz_q);
      uf      = !carry_q && (exp_ext <= lz_ext);
      exp_f   = (carry_q ? exp_ext + XW'(1) : exp_ext - lz_ext) + XW'(mant_r[MAN_W+1]);
      frac_f  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
      ovf     = !uf && (exp_f >= EXP_TOP);
      to_inf  = (rm == 2'd0) || ((rm == 2'd2) && !sign_q) || ((rm == 2'd3) && sign_q);

      res_d = {sign_q, exp_f[EXP_W-1:0], frac_f};
      ovf_d = 1'b0;
      uf_d  = 1'b0;
      inx_d = inx;
      if (spec_q) begin
         res_d = spec_res_q;
         inx_d = 1'b0;
      end else if (zero_q) begin
         res_d = {(rm == 2'd3), {(W-1){1'b0}}};
         inx_d = 1'b0;
      end else if (ovf) begin
         res_d = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                        : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         ovf_d = 1'b1;
         inx_d = 1'b1;
      end else if (uf) begin
         res_d = {sign_q, {EXP_W{1'b0}}, frac_f};
         uf_d  = inx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q <= '0;
         spec_q     <= 1'b0;
         zero_q     <= 1'b0;
         sign_q     <= 1'b0;
         carry_q    <= 1'b0;
         stk_q      <= 1'b0;
         spec_res_q <= '0;
         lz_q       <= '0;
         man_q      <= '0;
         exp_q      <= '0;
         result     <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         inexact    <= 1'b0;
      end else begin
         if (s2_ready) begin
            vld_pipe_q[2] <= vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
               result    <= res_d;
               overflow  <= ovf_d;
               underflow <= uf_d;
               inexact   <= inx_d;
            end
         end
         if (in_ready) begin
            vld_pipe_q[1] <= in_valid;
            if (in_valid) begin
               spec_q     <= spec_d;
               zero_q     <= zero_d;
               sign_q     <= aligned_sign;
               carry_q    <= carry_out;
               stk_q      <= sticky;
               spec_res_q <= spec_res_d;
               lz_q       <= lz_d;
               man_q      <= man_d;
               exp_q      <= exponent_in;
            end
         end
      end
   end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Table-driven scoreboard bench for fp_norm_round_pipe (EXP_W=8, MAN_W=23).
module tb_fp_norm_round_pipe;
   typedef struct {
      int          id;
      logic [31:0] a, b;
      logic        an, bn, ai, bi, az, bz;
      logic        sg;
      logic [31:0] ar;
      logic        co, st;
      logic [7:0]  ex;
      logic [1:0]  rm;
      logic [31:0] res;
      logic        ov, uf, ix;
   } vec_t;

   logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, aligned_result, result;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        aligned_sign, carry_out, sticky;
   logic [7:0]  exponent_in;
   logic [1:0]  rnd_mode;
   logic        overflow, underflow, inexact;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic rand_done;

   fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .a_nan(a_nan), .b_nan(b_nan), .a_inf(a_inf), .b_inf(b_inf),
      .a_zero(a_zero), .b_zero(b_zero), .aligned_sign(aligned_sign),
      .aligned_result(aligned_result), .carry_out(carry_out), .sticky(sticky),
      .exponent_in(exponent_in), .rnd_mode(rnd_mode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow),
      .underflow(underflow), .inexact(inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t nv(input logic [31:0] ar, input logic co, input logic st,
                               input logic [7:0] ex, input logic sg, input logic [1:0] rm,
                               input logic [31:0] res, input logic ov, input logic uf,
                               input logic ix);
      vec_t v;
      v.id = 0; v.a = '0; v.b = '0;
      {v.an, v.bn, v.ai, v.bi, v.az, v.bz} = 6'b0;
      v.sg = sg; v.ar = ar; v.co = co; v.st = st; v.ex = ex; v.rm = rm;
      v.res = res; v.ov = ov; v.uf = uf; v.ix = ix;
      return v;
   endfunction

   // normal-path fields are live so the special decision must override them
   function automatic vec_t sp(input logic [31:0] va, input logic [31:0] vb,
                               input logic [5:0] fl, input logic [31:0] res);
      vec_t v;
      v = nv(32'h80000180, 1'b0, 1'b1, 8'd127, 1'b1, 2'd0, res, 1'b0, 1'b0, 1'b0);
      v.a = va; v.b = vb;
      {v.an, v.bn, v.ai, v.bi, v.az, v.bz} = fl;
      return v;
   endfunction

   function automatic void add(input vec_t v);
      vec_t t;
      t = v;
      t.id = vecs.size();
      vecs.push_back(t);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic send(input vec_t v);
      int cyc;
      a = v.a; b = v.b;
      {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero} = {v.an, v.bn, v.ai, v.bi, v.az, v.bz};
      aligned_sign = v.sg; aligned_result = v.ar; carry_out = v.co; sticky = v.st;
      exponent_in = v.ex; rnd_mode = v.rm;
      in_valid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!in_ready && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
      if (in_ready) exp_q.push_back(v);
      else begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout vec%0d: in_ready=0 want 1", v.id);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check("drain_pending", exp_q.size(), 0);
   endtask

   // scoreboard: a transfer happens at the next rising edge
   always @(negedge clk) begin
      vec_t e;
      if (!reset && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got %h want none", result);
         end else begin
            e = exp_q.pop_front();
            if (result !== e.res || overflow !== e.ov || underflow !== e.uf || inexact !== e.ix) begin
               n_err++;
               $display("FAIL vec%0d: got res=%h ovf=%b uf=%b inx=%b want res=%h ovf=%b uf=%b inx=%b",
                        e.id, result, overflow, underflow, inexact, e.res, e.ov, e.uf, e.ix);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] held;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rand_done = 1'b0;
      a = '0; b = '0; {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero} = 6'b0;
      aligned_sign = 1'b0; aligned_result = '0; carry_out = 1'b0; sticky = 1'b0;
      exponent_in = '0; rnd_mode = 2'd0;

      add(nv(32'h00000000, 1, 0, 8'd127, 0, 0, 32'h40000000, 0, 0, 0));
      add(nv(32'h40000000, 0, 0, 8'd127, 0, 0, 32'h3F000000, 0, 0, 0));
      add(nv(32'h80000180, 0, 0, 8'd127, 0, 0, 32'h3F800002, 0, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 0, 0, 32'h7F800000, 1, 0, 1));
      add(sp(32'h7F800000, 32'hFF800000, 6'b001100, 32'h7FFFFFFF));
      add(sp(32'h7FC00001, 32'h7FC00002, 6'b110000, 32'h7FC00001));
      add(sp(32'h7F800000, 32'hFFC00003, 6'b011000, 32'hFFC00003));
      add(sp(32'hFF800000, 32'h00000000, 6'b001001, 32'hFF800000));
      add(sp(32'h80000000, 32'h00000000, 6'b000011, 32'h80000000));
      add(sp(32'h00000000, 32'h12345678, 6'b000010, 32'h12345678));
      add(nv(32'h00000000, 0, 1, 8'd100, 1, 0, 32'h00000000, 0, 0, 0));
      add(nv(32'h80000000, 0, 0, 8'd127, 1, 0, 32'hBF800000, 0, 0, 0));
      add(nv(32'hFFFFFF80, 0, 0, 8'd127, 0, 0, 32'h40000000, 0, 0, 1));
      add(nv(32'h80000080, 0, 0, 8'd127, 0, 0, 32'h3F800000, 0, 0, 1));
      add(nv(32'h80000000, 0, 1, 8'd127, 0, 0, 32'h3F800000, 0, 0, 1));
      add(nv(32'h00000180, 1, 0, 8'd127, 0, 0, 32'h40000001, 0, 0, 1));
      add(nv(32'h800000C0, 0, 0, 8'd0,   0, 0, 32'h00000001, 0, 1, 1));
      add(nv(32'h40000000, 0, 0, 8'd1,   1, 0, 32'h80000000, 0, 0, 0));
      add(nv(32'h00000001, 0, 0, 8'd127, 0, 0, 32'h30000000, 0, 0, 0));
      add(nv(32'h80000000, 0, 0, 8'd255, 1, 0, 32'hFF800000, 1, 0, 1));
`ifdef FPNORM_ROUND_MODES_EN
      add(nv(32'h80000180, 0, 0, 8'd127, 0, 1, 32'h3F800001, 0, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 0, 1, 32'h7F7FFFFF, 1, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 1, 2, 32'hFF7FFFFF, 1, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 1, 3, 32'hFF800000, 1, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 0, 3, 32'h7F7FFFFF, 1, 0, 1));
      add(nv(32'h80000001, 0, 0, 8'd127, 0, 2, 32'h3F800001, 0, 0, 1));
      add(nv(32'h80000001, 0, 0, 8'd127, 1, 2, 32'hBF800000, 0, 0, 1));
      add(nv(32'h00000000, 0, 0, 8'd100, 0, 3, 32'h80000000, 0, 0, 0));
`else
      add(nv(32'h80000180, 0, 0, 8'd127, 0, 1, 32'h3F800002, 0, 0, 1));
      add(nv(32'h00000000, 1, 0, 8'd254, 0, 1, 32'h7F800000, 1, 0, 1));
      add(nv(32'h00000000, 0, 0, 8'd100, 0, 3, 32'h00000000, 0, 0, 0));
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      reset = 1'b0;

      // latency: accepted at edge N, visible after edge N+1
      send(vecs[0]);
      check("lat_out_valid_early", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_out_valid_2cyc", {31'b0, out_valid}, 32'd1);
      drain();

      // pass 1: full throughput
      for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
      drain();

      // pass 2: random downstream backpressure
      fork
         begin
            for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // stall: three back-to-back with out_ready held low
      out_ready = 1'b0;
      fork
         begin
            send(vecs[2]); send(vecs[5]); send(vecs[12]);
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("stall_in_ready_low", {31'b0, in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            held = result;
            repeat (3) begin
               @(negedge clk);
               check("stall_result_held", result, held);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with both stages occupied
      out_ready = 1'b0;
      send(vecs[3]); send(vecs[4]);
      check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      exp_q.delete();
      a = vecs[1].a; aligned_result = vecs[1].ar; carry_out = vecs[1].co;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_result", result, 32'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_no_output", {31'b0, out_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
